led_pattern_gen: RTL and testbench
==================================

LED_PATTERN_GEN -- requirements
Module: led_pattern_gen

Interface
REQ-001 SHALL have parameter LED_W, default 4, number of LEDs (legal range 2..32).
REQ-002 SHALL have parameter CLK_HZ, default 50_000_000, sys_clk frequency in Hz.
REQ-003 SHALL have parameter STEP_MS, default 200, base step period in ms; STEP_CYC = CLK_HZ/1000*STEP_MS, computed at elaboration.
REQ-004 SHALL have port sys_clk, input, 1, system clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port mode, input, 2, pattern select: 0 rotate-left, 1 rotate-right, 2 bounce, 3 blink-all.
REQ-007 SHALL have port run, input, 1: 1 advances the pattern, 0 freezes the pattern and step counter.
REQ-008 SHALL have port speed, input, 2: step period = max(1, STEP_CYC >> speed) cycles.
REQ-009 SHALL have port led, output, LED_W, registered LED drive, 1 = lit.
REQ-010 SHALL have port step_pulse, output, 1, registered one-cycle strobe, high in the same cycle the new pattern appears on led.

Function
REQ-011 SHALL count cnt from 0 to period-1 while run=1, wrapping to 0, and SHALL assert an internal tick on the cycle cnt >= period-1.
REQ-012 SHALL apply the >= comparison so that lowering the period mid-count produces a tick on the next run cycle instead of a counter overrun.
REQ-013 SHALL hold cnt, led and bounce direction unchanged while run=0; step_pulse SHALL be 0.
REQ-014 SHALL, on tick in mode 0, update led to {led[LED_W-2:0], led[LED_W-1]}.
REQ-015 SHALL, on tick in mode 1, update led to {led[0], led[LED_W-1:1]}.
REQ-016 SHALL, in mode 2, move a single lit bit one position per tick, reversing at bit LED_W-1 and at bit 0 without repeating an endpoint (LED_W=4: 0001,0010,0100,1000,0100,0010,0001,0010,...).
REQ-017 SHALL, on tick in mode 3, invert every bit of led (all-on / all-off toggle).
REQ-018 SHALL register mode; when the registered mode differs from the input, the next edge SHALL load the seed (modes 0-2: only bit 0 set, direction left; mode 3: all ones), clear cnt, and keep step_pulse 0, regardless of run.
REQ-019 SHALL give mode reload priority over a coincident tick.
REQ-020 SHALL always have exactly one bit set in led in modes 0-2, after any sequence of inputs.

Reset
REQ-021 SHALL, while rst_n=0, force led to only bit 0 set, cnt to 0, registered mode to 0, direction to left, and step_pulse to 0.
REQ-022 SHALL, after rst_n deasserts, produce the first step no earlier than period cycles later; a reset mid-count SHALL discard the partial count.

Configuration
REQ-023 SHALL, when macro LED_PWM_DIM_EN is defined, add input port duty (4 bits) and a free-running 4-bit PWM counter reset to 0; led SHALL then be the pattern AND-ed with the registered value (pwm_cnt < duty), giving duty/16 brightness, with duty=0 always dark; step_pulse timing is unchanged.
REQ-024 SHALL, when LED_PWM_DIM_EN is not defined, omit the duty port and the PWM counter, and drive led with the pattern register directly.

Verification (CLK_HZ=1000, STEP_MS=4, so STEP_CYC=4, LED_W=4)
REQ-025 SHALL check: reset release, mode=0, run=1, speed=0 -> led 0001,0010,0100,1000,0001 with step_pulse every 4th cycle, coincident with each change.
REQ-026 SHALL check: mode=2, run=1 for 8 ticks -> led 0001,0010,0100,1000,0100,0010,0001,0010,0100.
REQ-027 SHALL check: run=0 for 20 cycles mid-count -> led and cnt frozen, step_pulse 0; run=1 -> remaining count resumes without restart.
REQ-028 SHALL check: switch mode 0->3 on the same edge a tick is due -> led=1111 next edge with no step_pulse, then 0000 after 4 cycles.
REQ-029 SHALL check: speed 0->2 when cnt=3 -> tick on next cycle, then every 1 cycle; rst_n pulse mid-count -> led=0001, next step 4 cycles after release.
REQ-030 SHALL check (LED_PWM_DIM_EN defined): duty=4, mode=3 with led pattern all ones -> led high 4 of every 16 cycles; duty=0 -> led 0000 always.

Source files
------------

// File: rtl/led_pattern_gen.sv
// LED pattern generator: rotate-left/right, bounce and blink-all with a programmable step rate.
// Optional PWM dimming via `define LED_PWM_DIM_EN (adds the 4-bit duty input).
module led_pattern_gen #(
  parameter int unsigned LED_W   = 4,
  parameter int unsigned CLK_HZ  = 50_000_000,
  parameter int unsigned STEP_MS = 200
) (
  input  logic             sys_clk,
  input  logic             rst_n,
  input  logic [1:0]       mode,
  input  logic             run,
  input  logic [1:0]       speed,
`ifdef LED_PWM_DIM_EN
  input  logic [3:0]       duty,
`endif
  output logic [LED_W-1:0] led,
  output logic             step_pulse
);

  localparam int unsigned StepCyc = CLK_HZ / 1000 * STEP_MS;
  localparam int unsigned CntW    = (StepCyc > 1) ? $clog2(StepCyc) : 1;
  localparam int unsigned PerW    = CntW + 1;

  localparam logic [PerW-1:0]  StepCycW = PerW'(StepCyc);
  localparam logic [LED_W-1:0] SeedOne  = LED_W'(1);
  localparam logic [LED_W-1:0] SeedAll  = '1;

  logic [1:0]       mode_q, mode_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [LED_W-1:0] pat_q, pat_d;
  logic             dir_q, dir_d;  // 0: moving toward MSB, 1: toward LSB
  logic             pulse_q, pulse_d;

  logic [PerW-1:0]  period;
  logic             reload;
  logic             tick;

  // Using >= lets a period shortened mid-count fire on the next run cycle.
  always_comb begin
    period = StepCycW >> speed;
    if (period == '0) begin
      period = PerW'(1);
    end
    reload = (mode != mode_q);
    tick   = run && (({1'b0, cnt_q} + PerW'(1)) >= period);
  end

  always_comb begin
    mode_d  = mode;
    cnt_d   = cnt_q;
    pat_d   = pat_q;
    dir_d   = dir_q;
    pulse_d = 1'b0;
    if (reload) begin
      cnt_d = '0;
      dir_d = 1'b0;
      pat_d = (mode == 2'd3) ? SeedAll : SeedOne;
    end else if (tick) begin
      cnt_d   = '0;
      pulse_d = 1'b1;
      unique case (mode_q)
        2'd0: pat_d = {pat_q[LED_W-2:0], pat_q[LED_W-1]};
        2'd1: pat_d = {pat_q[0], pat_q[LED_W-1:1]};
        2'd2: begin
          // Reverse at the ends so endpoints are not repeated.
          if (!dir_q) begin
            if (pat_q[LED_W-1]) begin
              pat_d = pat_q >> 1;
              dir_d = 1'b1;
            end else begin
              pat_d = pat_q << 1;
            end
          end else begin
            if (pat_q[0]) begin
              pat_d = pat_q << 1;
              dir_d = 1'b0;
            end else begin
              pat_d = pat_q >> 1;
            end
          end
        end
        2'd3: pat_d = ~pat_q;
      endcase
    end else if (run) begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q  <= 2'd0;
      cnt_q   <= '0;
      pat_q   <= SeedOne;
      dir_q   <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      mode_q  <= mode_d;
      cnt_q   <= cnt_d;
      pat_q   <= pat_d;
      dir_q   <= dir_d;
      pulse_q <= pulse_d;
    end
  end

`ifdef LED_PWM_DIM_EN
  logic [3:0] pwm_cnt_q, pwm_cnt_d;
  logic       pwm_on_q, pwm_on_d;

  always_comb begin
    pwm_cnt_d = pwm_cnt_q + 4'd1;
    pwm_on_d  = (pwm_cnt_q < duty);
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_cnt_q <= 4'd0;
      pwm_on_q  <= 1'b0;
    end else begin
      pwm_cnt_q <= pwm_cnt_d;
      pwm_on_q  <= pwm_on_d;
    end
  end

  assign led = pat_q & {LED_W{pwm_on_q}};
`else
  assign led = pat_q;
`endif

  assign step_pulse = pulse_q;

endmodule

// File: tb/tb_led_pattern_gen.sv
// Self-checking bench for led_pattern_gen: directed vectors plus randomized run against a model.
// Honours `define LED_PWM_DIM_EN when the design is built with dimming.
module tb_led_pattern_gen;

  localparam int W        = 4;
  localparam int CLK_HZ   = 1000;
  localparam int STEP_MS  = 4;
  localparam int STEP_CYC = CLK_HZ / 1000 * STEP_MS;

  logic         sys_clk;
  logic         rst_n;
  logic [1:0]   mode;
  logic         run;
  logic [1:0]   speed;
  logic [W-1:0] led;
  logic         step_pulse;
`ifdef LED_PWM_DIM_EN
  logic [3:0]   duty;
`endif

  led_pattern_gen #(
    .LED_W  (W),
    .CLK_HZ (CLK_HZ),
    .STEP_MS(STEP_MS)
  ) dut (
    .sys_clk   (sys_clk),
    .rst_n     (rst_n),
    .mode      (mode),
    .run       (run),
    .speed     (speed),
`ifdef LED_PWM_DIM_EN
    .duty      (duty),
`endif
    .led       (led),
    .step_pulse(step_pulse)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  int checks = 0;
  int errors = 0;

  // Model: rotate modes track the lit position, bounce tracks a phase around a
  // round trip of 2*(W-1) steps, blink tracks an on/off flag.
  int m_mode, m_cnt, m_idx;
  bit m_on, m_pulse;
  int m_pwm_cnt;
  bit m_pwm_on;

  typedef struct {
    logic [1:0]   mode;
    logic         run;
    logic [1:0]   speed;
    logic [W-1:0] exp_led;
    logic         exp_pulse;
  } vec_t;

  function automatic logic [W-1:0] pat_exp();
    int pos;
    case (m_mode)
      0, 1: return W'(1) << m_idx;
      2: begin
        pos = (m_idx < W) ? m_idx : 2 * (W - 1) - m_idx;
        return W'(1) << pos;
      end
      default: return m_on ? {W{1'b1}} : {W{1'b0}};
    endcase
  endfunction

  function automatic logic [W-1:0] gate(input logic [W-1:0] v);
`ifdef LED_PWM_DIM_EN
    return v & {W{m_pwm_on}};
`else
    return v;
`endif
  endfunction

  task automatic model_reset();
    m_mode = 0; m_cnt = 0; m_idx = 0; m_on = 1'b0; m_pulse = 1'b0;
    m_pwm_cnt = 0; m_pwm_on = 1'b0;
  endtask

  task automatic model_step();
    int per;
    if (!rst_n) begin
      model_reset();
      return;
    end
`ifdef LED_PWM_DIM_EN
    m_pwm_on  = (m_pwm_cnt < int'(duty));
    m_pwm_cnt = (m_pwm_cnt + 1) % 16;
`endif
    m_pulse = 1'b0;
    if (int'(mode) != m_mode) begin
      m_mode = int'(mode);
      m_idx  = 0;
      m_on   = 1'b1;
      m_cnt  = 0;
    end else if (run) begin
      per = STEP_CYC >> speed;
      if (per < 1) per = 1;
      if (m_cnt >= per - 1) begin
        m_cnt   = 0;
        m_pulse = 1'b1;
        case (m_mode)
          0: m_idx = (m_idx + 1) % W;
          1: m_idx = (m_idx + W - 1) % W;
          2: m_idx = (m_idx + 1) % (2 * (W - 1));
          default: m_on = !m_on;
        endcase
      end else begin
        m_cnt++;
      end
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic expect_out(input string name, input logic [W-1:0] exp_led, input logic exp_p);
    check({name, "_led"}, 32'(led), 32'(gate(exp_led)));
    check({name, "_pulse"}, 32'(step_pulse), 32'(exp_p));
  endtask

  // One rising edge, then compare against the model away from the edge.
  task automatic clk_edge();
    @(posedge sys_clk);
    model_step();
    #1;
    check("led_vs_model", 32'(led), 32'(gate(pat_exp())));
    check("pulse_vs_model", 32'(step_pulse), 32'(m_pulse));
`ifndef LED_PWM_DIM_EN
    if (m_mode < 3) check("onehot", 32'($countones(led)), 32'd1);
`endif
  endtask

  vec_t         tbl[16];
  logic [W-1:0] bnc[8];
  logic [W-1:0] fast[5];
  logic [W-1:0] prev;

  initial begin
    tbl = '{
      '{2'd0, 1'b1, 2'd0, 4'b0001, 1'b0}, '{2'd0, 1'b1, 2'd0, 4'b0001, 1'b0},
      '{2'd0, 1'b1, 2'd0, 4'b0001, 1'b0}, '{2'd0, 1'b1, 2'd0, 4'b0010, 1'b1},
      '{2'd0, 1'b1, 2'd0, 4'b0010, 1'b0}, '{2'd0, 1'b1, 2'd0, 4'b0010, 1'b0},
      '{2'd0, 1'b1, 2'd0, 4'b0010, 1'b0}, '{2'd0, 1'b1, 2'd0, 4'b0100, 1'b1},
      '{2'd0, 1'b1, 2'd0, 4'b0100, 1'b0}, '{2'd0, 1'b1, 2'd0, 4'b0100, 1'b0},
      '{2'd0, 1'b1, 2'd0, 4'b0100, 1'b0}, '{2'd0, 1'b1, 2'd0, 4'b1000, 1'b1},
      '{2'd0, 1'b1, 2'd0, 4'b1000, 1'b0}, '{2'd0, 1'b1, 2'd0, 4'b1000, 1'b0},
      '{2'd0, 1'b1, 2'd0, 4'b1000, 1'b0}, '{2'd0, 1'b1, 2'd0, 4'b0001, 1'b1}
    };
    bnc  = '{4'b0010, 4'b0100, 4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b0010, 4'b0100};
    fast = '{4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};

    rst_n = 1'b0; mode = 2'd0; run = 1'b1; speed = 2'd0;
`ifdef LED_PWM_DIM_EN
    duty = 4'd15;
`endif
    model_reset();
    repeat (3) clk_edge();
    expect_out("reset", 4'b0001, 1'b0);
    rst_n = 1'b1;

    // Rotate-left from reset, step every 4th cycle.
    for (int i = 0; i < 16; i++) begin
      mode = tbl[i].mode; run = tbl[i].run; speed = tbl[i].speed;
      clk_edge();
      expect_out("tbl_rotl", tbl[i].exp_led, tbl[i].exp_pulse);
    end

    // Freeze mid-count, then resume the remaining count.
    repeat (2) clk_edge();
    run = 1'b0;
    for (int i = 0; i < 20; i++) begin
      clk_edge();
      expect_out("frozen", 4'b0001, 1'b0);
    end
    run = 1'b1;
    clk_edge(); expect_out("resume_wait", 4'b0001, 1'b0);
    clk_edge(); expect_out("resume_step", 4'b0010, 1'b1);

    // Mode change on the edge a tick is due: reload wins.
    repeat (3) clk_edge();
    expect_out("pre_switch", 4'b0010, 1'b0);
    mode = 2'd3;
    clk_edge(); expect_out("reload_blink", 4'b1111, 1'b0);
    repeat (3) begin
      clk_edge(); expect_out("blink_hold", 4'b1111, 1'b0);
    end
    clk_edge(); expect_out("blink_toggle", 4'b0000, 1'b1);

    // Bounce through 8 ticks.
    mode = 2'd2;
    clk_edge(); expect_out("reload_bounce", 4'b0001, 1'b0);
    prev = 4'b0001;
    for (int i = 0; i < 8; i++) begin
      repeat (3) begin
        clk_edge(); expect_out("bounce_hold", prev, 1'b0);
      end
      clk_edge(); expect_out("bounce_step", bnc[i], 1'b1);
      prev = bnc[i];
    end

    // Period shortened with cnt already past the new limit.
    mode = 2'd0;
    clk_edge(); expect_out("reload_rot", 4'b0001, 1'b0);
    repeat (3) clk_edge();
    speed = 2'd2;
    for (int i = 0; i < 5; i++) begin
      clk_edge(); expect_out("fast_step", fast[i], 1'b1);
    end

    // Reset mid-count discards the partial count.
    speed = 2'd0;
    repeat (2) clk_edge();
    expect_out("midcount", 4'b0010, 1'b0);
    rst_n = 1'b0;
    model_reset();
    #1;
    expect_out("async_rst", 4'b0001, 1'b0);
    clk_edge(); expect_out("in_rst", 4'b0001, 1'b0);
    rst_n = 1'b1;
    repeat (3) begin
      clk_edge(); expect_out("post_rst_hold", 4'b0001, 1'b0);
    end
    clk_edge(); expect_out("post_rst_step", 4'b0010, 1'b1);

`ifdef LED_PWM_DIM_EN
    begin
      int lit;
      mode = 2'd3;
      clk_edge();
      run  = 1'b0;
      duty = 4'd4;
      lit  = 0;
      for (int i = 0; i < 32; i++) begin
        clk_edge();
        if (led == 4'b1111) lit++;
      end
      check("pwm_duty4_lit", 32'(lit), 32'd8);
      duty = 4'd0;
      for (int i = 0; i < 32; i++) begin
        clk_edge();
        check("pwm_duty0_dark", 32'(led), 32'd0);
      end
      duty = 4'd15;
      run  = 1'b1;
    end
`endif

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      if (!rst_n) begin
        rst_n = 1'b1;
      end else if ($urandom_range(0, 199) == 0) begin
        rst_n = 1'b0;
        model_reset();
        #1;
        expect_out("rand_rst", 4'b0001, 1'b0);
      end
      if ($urandom_range(0, 15) == 0) mode = 2'($urandom_range(0, 3));
      run = ($urandom_range(0, 4) != 0);
      if ($urandom_range(0, 9) == 0) speed = 2'($urandom_range(0, 3));
`ifdef LED_PWM_DIM_EN
      if ($urandom_range(0, 31) == 0) duty = 4'($urandom_range(0, 15));
`endif
      clk_edge();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
